// File: rtl/road_pkg.sv
// road_pkg: colour codes, curve states and curve constants shared by the road background generator
package road_pkg;
  localparam logic [2:0] BLACK = 3'b000, GREEN = 3'b010, RED = 3'b100, YELLOW = 3'b110, WHITE = 3'b111;
  typedef logic [1:0] curve_t;
  localparam curve_t STRAIGHT = 2'd0, DRIFT_L = 2'd1, DRIFT_R = 2'd2;
  localparam int SEG_FRAMES = 60;
  localparam int MAX_OFFSET = 64;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
endpackage

// File: rtl/road_background_gen_if.sv
// road_background_gen_if: frame tick, pixel coordinates, game inputs and registered colour
interface road_background_gen_if;
  logic update_signal;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [2:0] speed;
  logic alive;
  logic [2:0] rgb;
  modport master(output update_signal, pixel_x, pixel_y, speed, alive, input rgb);
  modport slave(input update_signal, pixel_x, pixel_y, speed, alive, output rgb);
endinterface

// File: rtl/road_lfsr.sv
// road_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable; exposes the two low bits
module road_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] pick
);
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr <= SEED;
    else if (en) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign pick = lfsr[1:0];
endmodule

// File: rtl/road_background_gen.sv
// road_background_gen: scrolling road background with lane marks and verge flash; define ROAD_CURVE_EN for a drifting road
module road_background_gen
  import road_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int LANE_W      = 64,
  parameter int BORDER_W    = 8,
  parameter int ROAD_X0     = 256,
  parameter int MARK_W      = 8,
  parameter int MARK_LEN    = 22,
  parameter int MARK_PERIOD = 64
) (
  input logic clk,
  input logic reset,
  road_background_gen_if.slave bus
);
  localparam int SW = $clog2(MARK_PERIOD);
  logic [SW-1:0] scroll;
  logic [SW-1:0] phase;
  logic [2:0] flash_cnt;
  logic [2:0] colour;
  logic [2:0] rgb;
  logic [7:0] offset;
  logic [11:0] x, rl, rr;
  logic on_line, on_mark, on_road;
  logic tick;
  assign tick = bus.update_signal & bus.alive;
  assign bus.rgb = rgb;
`ifdef ROAD_CURVE_EN
  localparam int CW = $clog2(SEG_FRAMES + 1);
  curve_t state;
  logic [CW-1:0] seg_cnt;
  logic [1:0] pick;
  logic seg_end;
  assign seg_end = tick && seg_cnt == CW'(1);
  road_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .en(seg_end), .pick(pick));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= STRAIGHT;
      seg_cnt <= CW'(SEG_FRAMES);
      offset  <= '0;
    end else if (tick) begin
      seg_cnt <= seg_end ? CW'(SEG_FRAMES) : seg_cnt - 1'b1;
      if (seg_end) state <= pick == 2'b01 ? DRIFT_L : pick == 2'b10 ? DRIFT_R : STRAIGHT;
      offset <= state == DRIFT_L && offset != 8'(-MAX_OFFSET) ? offset - 1'b1 :
                state == DRIFT_R && offset != 8'(MAX_OFFSET)  ? offset + 1'b1 : offset;
    end
`else
  assign offset = '0;
`endif
  always_comb begin
    x = {2'b00, bus.pixel_x};
    rl = 12'(ROAD_X0) + {{4{offset[7]}}, offset};
    rr = rl + 12'(NUM_LANES * LANE_W);
    on_line = (x >= rl - 12'(BORDER_W) && x < rl) || (x >= rr && x < rr + 12'(BORDER_W));
    on_road = x >= rl && x < rr;
    on_mark = 1'b0;
    for (int k = 1; k < NUM_LANES; k++)
      on_mark = on_mark | (x >= rl + 12'(k * LANE_W - MARK_W / 2) && x < rl + 12'(k * LANE_W + MARK_W / 2));
    phase = SW'(bus.pixel_y - 10'(scroll));
    colour = on_line ? WHITE :
             on_mark ? (phase < SW'(MARK_LEN) ? YELLOW : BLACK) :
             on_road ? BLACK :
             (bus.alive | flash_cnt[2]) ? GREEN : RED;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scroll    <= '0;
      flash_cnt <= '0;
      rgb       <= BLACK;
    end else begin
      if (tick) scroll <= scroll + SW'(bus.speed);
      flash_cnt <= bus.alive ? 3'd0 : flash_cnt + 3'(bus.update_signal);
      rgb <= colour;
    end
endmodule

// File: tb/tb_road_background_gen.sv
// tb_road_background_gen: directed literals plus a per-cycle behavioural model of the road background
module tb_road_background_gen;
  localparam logic [2:0] K = 3'b000, G = 3'b010, R = 3'b100, Y = 3'b110, W = 3'b111;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  road_background_gen_if b();
  road_background_gen dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;

  int m_scroll, m_flash, m_off;
  logic [2:0] exp_rgb;
`ifdef ROAD_CURVE_EN
  int m_state, m_cnt;
  logic [15:0] m_lfsr;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int taps[4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= l[16 - taps[i]];
    return {fb, l[15:1]};
  endfunction
`endif

  function automatic logic [2:0] colour(input int x, input int y, input int s, input int off, input bit alive, input int fl);
    int rl = 256 + off;
    int rr = rl + 2 * 64;
    if ((x >= rl - 8 && x <= rl - 1) || (x >= rr && x <= rr + 7)) return W;
    if (x >= rl + 64 - 4 && x <= rl + 64 + 3) return ((((y - s) % 64) + 64) % 64 < 22) ? Y : K;
    if (x >= rl && x <= rr - 1) return K;
    return (alive || fl >= 4) ? G : R;
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_scroll <= 0; m_flash <= 0; m_off <= 0; exp_rgb <= K;
`ifdef ROAD_CURVE_EN
      m_state <= 0; m_cnt <= 60; m_lfsr <= 16'hACE1;
`endif
    end else begin
      exp_rgb <= colour(int'(b.pixel_x), int'(b.pixel_y), m_scroll, m_off, b.alive, m_flash);
      m_flash <= b.alive ? 0 : (m_flash + int'(b.update_signal)) % 8;
      if (b.update_signal && b.alive) begin
        m_scroll <= (m_scroll + int'(b.speed)) % 64;
`ifdef ROAD_CURVE_EN
        if (m_state == 1 && m_off > -64) m_off <= m_off - 1;
        if (m_state == 2 && m_off < 64) m_off <= m_off + 1;
        if (m_cnt == 1) begin
          m_cnt <= 60;
          m_state <= (m_lfsr % 4 == 1) ? 1 : (m_lfsr % 4 == 2) ? 2 : 0;
          m_lfsr <= lfsr_next(m_lfsr);
        end else m_cnt <= m_cnt - 1;
`endif
      end
    end

  task automatic check(input string nm, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: rgb=%b expected=%b", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) if (chk_en) check("model", b.rgb, exp_rgb);

  task automatic pix(input int x, input int y, input logic [2:0] want, input string nm);
    b.pixel_x = 10'(x);
    b.pixel_y = 10'(y);
    @(negedge clk);
    check(nm, b.rgb, want);
  endtask

  task automatic tick();
    b.update_signal = 1'b1;
    @(negedge clk);
    b.update_signal = 1'b0;
  endtask

  logic [2:0] flash_exp[8] = '{R, R, R, G, G, G, G, R};

  initial begin
    reset = 1'b1;
    b.update_signal = 1'b0; b.pixel_x = '0; b.pixel_y = '0; b.speed = '0; b.alive = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rgb", b.rgb, K);
    reset = 1'b0;
    chk_en = 1'b1;
    pix(250, 0, W, "verge_line_250");
    pix(300, 0, K, "road_300");
    pix(320, 0, Y, "mark_320_0");
    pix(320, 30, K, "mark_gap_320_30");
    pix(247, 0, G, "verge_247");
    pix(248, 0, W, "line_edge_248");
    pix(255, 0, W, "line_edge_255");
    pix(256, 0, K, "road_edge_256");
    pix(316, 0, Y, "mark_edge_316");
    pix(315, 0, K, "mark_out_315");
    pix(383, 0, K, "road_edge_383");
    pix(384, 0, W, "rline_384");
    pix(391, 0, W, "rline_391");
    pix(392, 0, G, "verge_392");
    b.speed = 3'd3;
    repeat (10) tick();
    pix(320, 40, Y, "scroll30_y40");
    pix(320, 29, K, "scroll30_y29");
    pix(320, 51, Y, "scroll30_y51");
    pix(320, 52, K, "scroll30_y52");
    repeat (12) tick();
    pix(320, 2, Y, "wrap_y2");
    pix(320, 1, K, "wrap_y1");
    pix(320, 23, Y, "wrap_y23");
    pix(320, 24, K, "wrap_y24");
    b.alive = 1'b0;
    pix(100, 0, R, "flash0");
    for (int i = 0; i < 8; i++) begin
      tick();
      pix(100, 0, flash_exp[i], $sformatf("flash%0d", (i + 1) % 8));
    end
    pix(320, 23, Y, "dead_hold_y23");
    pix(320, 24, K, "dead_hold_y24");
    b.alive = 1'b1;
    pix(100, 0, G, "alive_green");
    b.alive = 1'b0;
    repeat (5) tick();
    pix(100, 0, G, "flash5_green");
    b.alive = 1'b1;
    pix(100, 0, G, "alive_again");
    b.alive = 1'b0;
    pix(100, 0, R, "flash_cleared");
    b.alive = 1'b1;
    b.speed = 3'd0;
    repeat (39) tick();
    pix(320, 2, Y, "speed0_y2");
    pix(320, 1, K, "speed0_y1");
`ifdef ROAD_CURVE_EN
    pix(254, 0, W, "drift_line_254");
    pix(246, 0, G, "drift_verge_246");
    pix(255, 0, K, "drift_road_255");
`else
    pix(247, 0, G, "flat_verge_247");
    pix(255, 0, W, "flat_line_255");
    pix(256, 0, K, "flat_road_256");
`endif
    for (int i = 0; i < 10000; i++) begin
      b.speed = 3'($urandom_range(0, 7));
      b.alive = $urandom_range(0, 7) != 0;
      b.pixel_x = ($urandom_range(0, 3) == 0) ? 10'(248 + m_off) : 10'($urandom_range(150, 460));
      b.pixel_y = 10'($urandom_range(0, 479));
      tick();
      b.pixel_x = ($urandom_range(0, 1) == 0) ? 10'(250) : 10'($urandom_range(150, 460));
      @(negedge clk);
    end
    b.alive = 1'b1;
    b.speed = 3'd5;
    b.update_signal = 1'b1;
    #2 reset = 1'b1;
    #1 check("reset_async_rgb", b.rgb, K);
    @(negedge clk);
    b.update_signal = 1'b0;
    check("reset_held_rgb", b.rgb, K);
    reset = 1'b0;
    pix(320, 0, Y, "post_reset_y0");
    pix(320, 22, K, "post_reset_y22");
    pix(250, 0, W, "post_reset_250");
    pix(256, 0, K, "post_reset_256");
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/road_background_gen.md
ROAD_BACKGROUND_GEN -- requirements
Module: road_background_gen

Interface
REQ-001 NUM_LANES, 2, lane count (1..4).
REQ-002 LANE_W, 64, lane width in pixels.
REQ-003 BORDER_W, 8, white verge-line width in pixels on each road side.
REQ-004 ROAD_X0, 256, nominal road left edge at zero offset.
REQ-005 MARK_W, 8, lane-mark width, centred on the lane boundary.
REQ-006 MARK_LEN, 22, lit mark length; MARK_PERIOD, 64, mark repeat period, power of two.
REQ-007 SEG_FRAMES, 60, frames per curve segment; MAX_OFFSET, 64, offset limit; LFSR_SEED, 16'hACE1.
REQ-008 clk  input  1  pixel clock.
REQ-009 reset  input  1  reset, asynchronous, active-high.
REQ-010 update_signal  input  1  one-clk frame tick.
REQ-011 pixel_x, pixel_y  input  10 each  current pixel coordinates.
REQ-012 speed  input  3  scroll pixels per frame.
REQ-013 alive  input  1  player alive flag.
REQ-014 rgb  output  3  registered pixel colour.

Function
REQ-015 Colours: 000 black, 010 green, 100 red, 110 yellow, 111 white.
REQ-016 road_left = ROAD_X0 + offset (signed 8-bit); road_right = road_left + NUM_LANES*LANE_W.
REQ-017 Left verge line x in [road_left-BORDER_W, road_left-1] and right verge line x in [road_right, road_right+BORDER_W-1] SHALL be white.
REQ-018 x in [road_left, road_right-1] SHALL be black, except lane marks.
REQ-019 Marks at k=1..NUM_LANES-1, x in [road_left+k*LANE_W-MARK_W/2, road_left+k*LANE_W+MARK_W/2-1]: yellow when ((pixel_y - scroll) mod MARK_PERIOD) < MARK_LEN, else black.
REQ-020 All other x SHALL be verge colour: green when alive=1; when alive=0, red if flash_cnt[2]=0, else green.
REQ-021 rgb SHALL be registered: colour for (pixel_x, pixel_y) appears one clk later.
REQ-022 On update_signal with alive=1: scroll <= (scroll + speed) mod MARK_PERIOD; speed=0 holds scroll.
REQ-023 With alive=0, scroll SHALL hold and flash_cnt (3-bit) SHALL increment, wrapping, on each update_signal; alive=1 clears flash_cnt on the next clk.
REQ-024 Curve FSM states STRAIGHT, DRIFT_L, DRIFT_R; segment counter decrements on each update_signal.
REQ-025 On a tick with counter=1: reload SEG_FRAMES; next state from LFSR[1:0] (01 DRIFT_L, 10 DRIFT_R, else STRAIGHT); LFSR advances one step.
REQ-026 Each tick: DRIFT_L decrements offset, DRIFT_R increments it, saturating at -MAX_OFFSET/+MAX_OFFSET; STRAIGHT holds it.
REQ-027 Offset and curve state SHALL change only on update_signal and SHALL freeze while alive=0.
REQ-028 Boundary priority: reset over update_signal; verge line over lane mark over road; region ranges are inclusive as stated.

Reset
REQ-029 Asynchronous reset SHALL set scroll=0, offset=0, state=STRAIGHT, counter=SEG_FRAMES, LFSR=LFSR_SEED, flash_cnt=0, rgb=000.
REQ-030 Reset mid-frame SHALL take effect immediately; the first rgb after release reflects the reset state.

Configuration
REQ-031 With ROAD_CURVE_EN defined: curve FSM, LFSR and offset logic are present as REQ-024..REQ-027.
REQ-032 Without ROAD_CURVE_EN: offset is constant 0, no FSM or LFSR logic; all other behaviour is unchanged.

Structure
REQ-033 Package road_pkg SHALL hold the colour constants and the curve-state enumeration.
REQ-034 Sub-module road_lfsr SHALL implement the 16-bit Fibonacci LFSR, taps 16,14,13,11, with step enable.

Verification
REQ-035 Defaults, after reset: pixel (250,0) -> white; (300,0) -> black; (320,0) -> yellow; (320,30) -> black; each valid one clk later.
REQ-036 speed=3, 10 ticks -> scroll=30; (320,40) -> yellow; after 22 ticks total -> scroll=2 (wrap).
REQ-037 alive=0, 8 ticks -> verge red for flash_cnt 0-3 and green for 4-7, scroll unchanged; alive=1 -> green, flash_cnt=0.
REQ-038 ROAD_CURVE_EN, 10000 ticks: |offset| <= 64, |delta offset| <= 1 per tick, state changes only every 60 ticks; left verge line tracks 248+offset.
REQ-039 Without ROAD_CURVE_EN, 10000 ticks -> offset stays 0; (250,y) stays white.
REQ-040 Assert reset during a tick mid-run -> all state and rgb at reset values; update_signal during reset is ignored.
